sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter WIDTH, default 6, SHALL set the adder sum width consumed.
REQ-002 Parameter COUNT, default 4, SHALL set the number of samples per batch; legal range 2..255.
REQ-003 Parameter ACC_WIDTH, default 10, SHALL set the Total width; ACC_WIDTH SHALL be greater than WIDTH.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 Sum  input  WIDTH  SHALL carry the upstream adder sum.
REQ-007 Cout  input  1  SHALL carry the upstream adder carry-out; sample value is {Cout,Sum}.
REQ-008 in_valid  input  1  SHALL indicate Sum/Cout hold a valid sample.
REQ-009 in_ready  output  1  SHALL indicate the block accepts a sample this cycle.
REQ-010 flush  input  1  SHALL request closing a partial batch.
REQ-011 Total  output  ACC_WIDTH  SHALL present the batch sum.
REQ-012 Overflow  output  1  SHALL flag that the batch sum saturated.
REQ-013 Samples  output  8  SHALL present the number of samples in the presented batch.
REQ-014 out_valid  output  1  SHALL indicate Total/Overflow/Samples are valid.
REQ-015 out_ready  input  1  SHALL indicate downstream accepts the result.

Function
REQ-016 Sample acceptance SHALL occur exactly on a rising edge where in_valid and in_ready are both 1.
REQ-017 FSM SHALL have states IDLE (no samples), ACCUM (1..COUNT-1 samples), HOLD (result presented).
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD, combinationally from state only.
REQ-019 On acceptance, accumulator SHALL add zero-extended {Cout,Sum}; if the true sum exceeds 2^ACC_WIDTH-1, accumulator SHALL saturate at all-ones and set the batch Overflow flag (sticky until batch hand-off).
REQ-020 IDLE -> ACCUM on acceptance when COUNT>1 samples remain; ACCUM -> HOLD on the edge accepting the COUNT-th sample.
REQ-021 flush asserted in ACCUM SHALL move to HOLD on that edge; a sample accepted on the same edge SHALL be included in the batch.
REQ-022 flush in IDLE with no sample accepted SHALL be ignored; flush with in_valid in IDLE SHALL produce a 1-sample batch in HOLD.
REQ-023 flush in HOLD SHALL be ignored.
REQ-024 out_valid SHALL be 1 exactly in HOLD; latency from final accepted sample to out_valid SHALL be one edge.
REQ-025 Total, Overflow, Samples SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 HOLD -> IDLE on an edge with out_ready=1; accumulator, Overflow, sample count SHALL clear on that edge.
REQ-027 No sample SHALL be accepted on the hand-off edge (in_ready=0 in HOLD); back-to-back batches incur one bubble cycle.
REQ-028 Samples SHALL equal COUNT for full batches and the accepted count for flushed batches.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, Total=0, Overflow=0, Samples=0, out_valid=0, in_ready=1 regardless of clk.
REQ-030 Reset asserted mid-batch or in HOLD SHALL discard the partial/pending result; no out_valid after release until a new batch completes.
REQ-031 Release of rst_n SHALL be synchronised externally; first acceptance may occur on the first edge after release.

Verification
REQ-032 Defaults, samples {Cout,Sum} = 10, 20, 30, 40 with in_valid continuous, out_ready=1 -> out_valid one edge after 4th sample, Total=100, Samples=4, Overflow=0.
REQ-033 Defaults, four samples of 127 -> Total=508, Overflow=0; with ACC_WIDTH=8 same stimulus -> Total=255, Overflow=1.
REQ-034 Samples 5, 6 then flush with third sample 7 on same cycle -> Total=18, Samples=3; flush alone in IDLE -> no out_valid.
REQ-035 Batch complete, out_ready held 0 for 5 cycles with in_valid=1 -> in_ready=0, Total stable, no sample lost; out_ready=1 -> IDLE next edge, next batch counts from 0.
REQ-036 rst_n pulsed low after 2 of 4 samples (Total=30) -> outputs zero asynchronously; subsequent 4 samples of 1 -> Total=4, Samples=4.

Source files
------------

// File: rtl/sum_accumulator.sv
// Batch accumulator: sums COUNT samples of {Cout,Sum} (or fewer on flush),
// saturating at all-ones, and holds the result until downstream takes it.
module sum_accumulator #(
    parameter int WIDTH     = 6,
    parameter int COUNT     = 4,
    parameter int ACC_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     Sum,
    input  logic                 Cout,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [ACC_WIDTH-1:0] Total,
    output logic                 Overflow,
    output logic [7:0]           Samples,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [7:0] BATCH_LEN = 8'(COUNT);

    state_t               state_q;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] sample;
    logic [ACC_WIDTH:0]   sumWide;
    logic                 accept;
    logic                 lastSample;

    assign sample     = ACC_WIDTH'({Cout, Sum});
    assign in_ready   = (state_q != HOLD);
    assign accept     = in_valid && in_ready;
    assign lastSample = accept && (cnt_d == BATCH_LEN);

    assign Total     = acc_q;
    assign Overflow  = ovf_q;
    assign Samples   = cnt_q;
    assign out_valid = (state_q == HOLD);

    // The extra top bit of sumWide catches a carry out of the accumulator.
    always_comb begin
        sumWide = {1'b0, acc_q} + {1'b0, sample};
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + 8'd1;
            if (sumWide[ACC_WIDTH]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sumWide[ACC_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_d;
                    cnt_q <= cnt_d;
                    if (accept) begin
                        state_q <= (flush || lastSample) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_d;
                    cnt_q <= cnt_d;
                    if (flush || lastSample) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // Hand-off clears the batch; no sample can enter on this edge.
                    if (out_ready) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= 8'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator; a second instance with ACC_WIDTH=8
// shares the stimulus to exercise saturation.
module tb_sum_accumulator;

    logic       clk;
    logic       rst_n;
    logic [5:0] sum;
    logic       cout;
    logic       inValid;
    logic       flush;
    logic       outReady;

    logic       inReady;
    logic [9:0] total;
    logic       overflow;
    logic [7:0] samples;
    logic       outValid;

    logic       inReady8;
    logic [7:0] total8;
    logic       overflow8;
    logic [7:0] samples8;
    logic       outValid8;

    int checksTotal  = 0;
    int checksPassed = 0;

    sum_accumulator #(.WIDTH(6), .COUNT(4), .ACC_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .Sum(sum), .Cout(cout), .in_valid(inValid),
        .in_ready(inReady), .flush(flush), .Total(total), .Overflow(overflow),
        .Samples(samples), .out_valid(outValid), .out_ready(outReady)
    );

    sum_accumulator #(.WIDTH(6), .COUNT(4), .ACC_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .Sum(sum), .Cout(cout), .in_valid(inValid),
        .in_ready(inReady8), .flush(flush), .Total(total8), .Overflow(overflow8),
        .Samples(samples8), .out_valid(outValid8), .out_ready(outReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then let a rising edge pass and settle.
    task automatic applyStimulus(input logic v, input logic [6:0] smp,
                                 input logic f, input logic r);
        inValid     = v;
        {cout, sum} = smp;
        flush       = f;
        outReady    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checksTotal++;
        assert (observed === expected) begin
            checksPassed++;
        end else begin
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        inValid  = 1'b0;
        sum      = '0;
        cout     = 1'b0;
        flush    = 1'b0;
        outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(outValid), 0);
        checkOutput("reset_in_ready", 32'(inReady), 1);
        checkOutput("reset_total", 32'(total), 0);
        checkOutput("reset_samples", 32'(samples), 0);
        checkOutput("reset_overflow", 32'(overflow), 0);
        rst_n = 1'b1;

        // Full batch 10+20+30+40, in_valid held high throughout.
        applyStimulus(1, 7'd10, 0, 1);
        applyStimulus(1, 7'd20, 0, 1);
        applyStimulus(1, 7'd30, 0, 1);
        checkOutput("b1_not_yet_valid", 32'(outValid), 0);
        applyStimulus(1, 7'd40, 0, 1);
        checkOutput("b1_out_valid", 32'(outValid), 1);
        checkOutput("b1_total", 32'(total), 100);
        checkOutput("b1_samples", 32'(samples), 4);
        checkOutput("b1_overflow", 32'(overflow), 0);
        checkOutput("b1_in_ready_hold", 32'(inReady), 0);
        applyStimulus(1, 7'd50, 0, 1);
        checkOutput("b1_handoff_valid", 32'(outValid), 0);
        checkOutput("b1_handoff_total", 32'(total), 0);
        checkOutput("b1_handoff_in_ready", 32'(inReady), 1);

        // Four samples of 127: fits in 10 bits, saturates in 8 bits.
        repeat (4) applyStimulus(1, 7'd127, 0, 0);
        checkOutput("b2_total", 32'(total), 508);
        checkOutput("b2_overflow", 32'(overflow), 0);
        checkOutput("b2_sat_valid", 32'(outValid8), 1);
        checkOutput("b2_sat_total", 32'(total8), 255);
        checkOutput("b2_sat_overflow", 32'(overflow8), 1);
        applyStimulus(0, 7'd0, 0, 1);
        checkOutput("b2_sat_cleared", 32'(overflow8), 0);

        // Flush together with the third sample closes a 3-sample batch.
        applyStimulus(1, 7'd5, 0, 0);
        applyStimulus(1, 7'd6, 0, 0);
        applyStimulus(1, 7'd7, 1, 0);
        checkOutput("b3_out_valid", 32'(outValid), 1);
        checkOutput("b3_total", 32'(total), 18);
        checkOutput("b3_samples", 32'(samples), 3);
        applyStimulus(0, 7'd0, 1, 0);
        checkOutput("b3_flush_in_hold_valid", 32'(outValid), 1);
        checkOutput("b3_flush_in_hold_total", 32'(total), 18);
        applyStimulus(0, 7'd0, 0, 1);
        applyStimulus(0, 7'd0, 1, 1);
        checkOutput("idle_flush_no_valid", 32'(outValid), 0);
        checkOutput("idle_flush_samples", 32'(samples), 0);

        // Back-pressure: result must stay put while in_valid keeps pushing.
        applyStimulus(1, 7'd1, 0, 0);
        applyStimulus(1, 7'd2, 0, 0);
        applyStimulus(1, 7'd3, 0, 0);
        applyStimulus(1, 7'd4, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 7'd9, 0, 0);
            checkOutput($sformatf("bp_in_ready_%0d", i), 32'(inReady), 0);
            checkOutput($sformatf("bp_total_%0d", i), 32'(total), 10);
            checkOutput($sformatf("bp_samples_%0d", i), 32'(samples), 4);
        end
        applyStimulus(1, 7'd9, 0, 1);
        checkOutput("bp_handoff_valid", 32'(outValid), 0);
        checkOutput("bp_handoff_samples", 32'(samples), 0);
        applyStimulus(1, 7'd9, 1, 0);
        checkOutput("one_sample_valid", 32'(outValid), 1);
        checkOutput("one_sample_total", 32'(total), 9);
        checkOutput("one_sample_samples", 32'(samples), 1);
        applyStimulus(0, 7'd0, 0, 1);

        // Asynchronous reset mid-batch discards the partial sum.
        applyStimulus(1, 7'd10, 0, 1);
        applyStimulus(1, 7'd20, 0, 1);
        checkOutput("mid_total", 32'(total), 30);
        checkOutput("mid_samples", 32'(samples), 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_total", 32'(total), 0);
        checkOutput("async_rst_samples", 32'(samples), 0);
        checkOutput("async_rst_valid", 32'(outValid), 0);
        checkOutput("async_rst_in_ready", 32'(inReady), 1);
        #1 rst_n = 1'b1;
        applyStimulus(1, 7'd1, 0, 1);
        applyStimulus(1, 7'd1, 0, 1);
        applyStimulus(1, 7'd1, 0, 1);
        checkOutput("post_rst_not_valid", 32'(outValid), 0);
        applyStimulus(1, 7'd1, 0, 1);
        checkOutput("post_rst_valid", 32'(outValid), 1);
        checkOutput("post_rst_total", 32'(total), 4);
        checkOutput("post_rst_samples", 32'(samples), 4);
        checkOutput("post_rst_overflow", 32'(overflow), 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
